// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: 16-entry in-order allocate, out-of-order
// completion, up to two in-order retirements per cycle, single-cycle flush.
module rob_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned RD_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               alloc_cnt,
    input  logic [RD_W-1:0]          alloc_rd_a,
    input  logic [RD_W-1:0]          alloc_rd_b,
    input  logic                     alloc_regwrite_a,
    input  logic                     alloc_regwrite_b,
    input  logic                     wb_valid_0,
    input  logic                     wb_valid_1,
    input  logic [$clog2(DEPTH)-1:0] wb_entry_0,
    input  logic [$clog2(DEPTH)-1:0] wb_entry_1,
    input  logic                     flush,
    output logic [$clog2(DEPTH)-1:0] rob_head,
    output logic [$clog2(DEPTH)-1:0] rob_tail,
    output logic [$clog2(DEPTH):0]   rob_count,
    output logic [$clog2(DEPTH):0]   rob_free,
    output logic                     alloc_err,
    output logic                     commit_valid_0,
    output logic                     commit_valid_1,
    output logic [$clog2(DEPTH)-1:0] commit_entry_0,
    output logic [$clog2(DEPTH)-1:0] commit_entry_1,
    output logic [RD_W-1:0]          commit_rd_0,
    output logic [RD_W-1:0]          commit_rd_1,
    output logic                     commit_regwrite_0,
    output logic                     commit_regwrite_1
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CAP   = DEPTH - 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, free_q, free_d;
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, rw_q, rw_d;
    logic [RD_W-1:0]  rd_q [DEPTH];
    logic [RD_W-1:0]  rd_d [DEPTH];

    logic             err_q, err_d;
    logic             cv0_q, cv0_d, cv1_q, cv1_d;
    logic [PTR_W-1:0] ce0_q, ce0_d, ce1_q, ce1_d;
    logic [RD_W-1:0]  crd0_q, crd0_d, crd1_q, crd1_d;
    logic             crw0_q, crw0_d, crw1_q, crw1_d;

    logic [1:0]       req_cnt, acc_cnt, ret_cnt;
    logic             alloc_ok, c0, c1;
    logic [PTR_W-1:0] head1, tail1;

    // Admission and retirement decisions, all from registered state
    always_comb begin
        req_cnt  = (alloc_cnt == 2'd3) ? 2'd0 : alloc_cnt;
        alloc_ok = CNT_W'(req_cnt) <= free_q;
        acc_cnt  = alloc_ok ? req_cnt : 2'd0;
        head1    = head_q + PTR_W'(1);
        tail1    = tail_q + PTR_W'(1);
        c0       = valid_q[head_q] & done_q[head_q];
        c1       = c0 & valid_q[head1] & done_q[head1];
        ret_cnt  = {1'b0, c0} + {1'b0, c1};
    end

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rw_d    = rw_q;
        rd_d    = rd_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = 1'b0;
        cv0_d   = 1'b0;
        cv1_d   = 1'b0;
        ce0_d   = '0;
        ce1_d   = '0;
        crd0_d  = '0;
        crd1_d  = '0;
        crw0_d  = 1'b0;
        crw1_d  = 1'b0;

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            tail_d  = head_q;
            count_d = '0;
        end else begin
            // Writeback only lands on entries valid before this edge
            if (wb_valid_0 && valid_q[wb_entry_0]) done_d[wb_entry_0] = 1'b1;
            if (wb_valid_1 && valid_q[wb_entry_1]) done_d[wb_entry_1] = 1'b1;

            if (c0) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                cv0_d  = 1'b1;
                ce0_d  = head_q;
                crd0_d = rd_q[head_q];
                crw0_d = rw_q[head_q];
            end
            if (c1) begin
                valid_d[head1] = 1'b0;
                done_d[head1]  = 1'b0;
                cv1_d  = 1'b1;
                ce1_d  = head1;
                crd1_d = rd_q[head1];
                crw1_d = rw_q[head1];
            end

            if (acc_cnt != 2'd0) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                rd_d[tail_q]    = alloc_rd_a;
                rw_d[tail_q]    = alloc_regwrite_a;
            end
            if (acc_cnt == 2'd2) begin
                valid_d[tail1] = 1'b1;
                done_d[tail1]  = 1'b0;
                rd_d[tail1]    = alloc_rd_b;
                rw_d[tail1]    = alloc_regwrite_b;
            end

            err_d   = (req_cnt != 2'd0) && !alloc_ok;
            tail_d  = tail_q + PTR_W'(acc_cnt);
            head_d  = head_q + PTR_W'(ret_cnt);
            count_d = count_q + CNT_W'(acc_cnt) - CNT_W'(ret_cnt);
        end
        free_d = CNT_W'(CAP) - count_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            free_q  <= CNT_W'(CAP);
            valid_q <= '0;
            done_q  <= '0;
            rw_q    <= '0;
            for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
            err_q   <= 1'b0;
            cv0_q   <= 1'b0;
            cv1_q   <= 1'b0;
            ce0_q   <= '0;
            ce1_q   <= '0;
            crd0_q  <= '0;
            crd1_q  <= '0;
            crw0_q  <= 1'b0;
            crw1_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            free_q  <= free_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            rw_q    <= rw_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cv0_q   <= cv0_d;
            cv1_q   <= cv1_d;
            ce0_q   <= ce0_d;
            ce1_q   <= ce1_d;
            crd0_q  <= crd0_d;
            crd1_q  <= crd1_d;
            crw0_q  <= crw0_d;
            crw1_q  <= crw1_d;
        end
    end

    assign rob_head          = head_q;
    assign rob_tail          = tail_q;
    assign rob_count         = count_q;
    assign rob_free          = free_q;
    assign alloc_err         = err_q;
    assign commit_valid_0    = cv0_q;
    assign commit_valid_1    = cv1_q;
    assign commit_entry_0    = ce0_q;
    assign commit_entry_1    = ce1_q;
    assign commit_rd_0       = crd0_q;
    assign commit_rd_1       = crd1_q;
    assign commit_regwrite_0 = crw0_q;
    assign commit_regwrite_1 = crw1_q;

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed self-checking bench for rob_ctrl with hand-computed expectations.
module tb_rob_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] alloc_cnt;
    logic [4:0] alloc_rd_a, alloc_rd_b;
    logic       alloc_regwrite_a, alloc_regwrite_b;
    logic       wb_valid_0, wb_valid_1;
    logic [3:0] wb_entry_0, wb_entry_1;
    logic       flush;
    logic [3:0] rob_head, rob_tail;
    logic [4:0] rob_count, rob_free;
    logic       alloc_err;
    logic       commit_valid_0, commit_valid_1;
    logic [3:0] commit_entry_0, commit_entry_1;
    logic [4:0] commit_rd_0, commit_rd_1;
    logic       commit_regwrite_0, commit_regwrite_1;

    int n_checks = 0;
    int n_errors = 0;

    rob_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alloc_cnt         (alloc_cnt),
        .alloc_rd_a        (alloc_rd_a),
        .alloc_rd_b        (alloc_rd_b),
        .alloc_regwrite_a  (alloc_regwrite_a),
        .alloc_regwrite_b  (alloc_regwrite_b),
        .wb_valid_0        (wb_valid_0),
        .wb_valid_1        (wb_valid_1),
        .wb_entry_0        (wb_entry_0),
        .wb_entry_1        (wb_entry_1),
        .flush             (flush),
        .rob_head          (rob_head),
        .rob_tail          (rob_tail),
        .rob_count         (rob_count),
        .rob_free          (rob_free),
        .alloc_err         (alloc_err),
        .commit_valid_0    (commit_valid_0),
        .commit_valid_1    (commit_valid_1),
        .commit_entry_0    (commit_entry_0),
        .commit_entry_1    (commit_entry_1),
        .commit_rd_0       (commit_rd_0),
        .commit_rd_1       (commit_rd_1),
        .commit_regwrite_0 (commit_regwrite_0),
        .commit_regwrite_1 (commit_regwrite_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alloc_cnt = 2'd0;
        alloc_rd_a = 5'd0;
        alloc_rd_b = 5'd0;
        alloc_regwrite_a = 1'b0;
        alloc_regwrite_b = 1'b0;
        wb_valid_0 = 1'b0;
        wb_valid_1 = 1'b0;
        wb_entry_0 = 4'd0;
        wb_entry_1 = 4'd0;
        flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [1:0] cnt, input logic [4:0] ra, input logic wa,
                         input logic [4:0] rb, input logic wb);
        idle();
        alloc_cnt = cnt;
        alloc_rd_a = ra;
        alloc_regwrite_a = wa;
        alloc_rd_b = rb;
        alloc_regwrite_b = wb;
        step();
    endtask

    task automatic wback(input logic v0, input logic [3:0] e0, input logic v1, input logic [3:0] e1);
        idle();
        wb_valid_0 = v0;
        wb_entry_0 = e0;
        wb_valid_1 = v1;
        wb_entry_1 = e1;
        step();
    endtask

    task automatic fill15();
        for (int i = 0; i < 7; i++) alloc(2'd2, 5'(i), 1'b1, 5'(i + 16), 1'b0);
        alloc(2'd1, 5'd30, 1'b1, 5'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_head", rob_head, 0);
        check("rst_tail", rob_tail, 0);
        check("rst_count", rob_count, 0);
        check("rst_free", rob_free, 15);
        check("rst_err", alloc_err, 0);
        check("rst_cv0", commit_valid_0, 0);

        // alloc_cnt==3 is a no-op
        alloc(2'd3, 5'd1, 1'b1, 5'd2, 1'b1);
        check("cnt3_tail", rob_tail, 0);
        check("cnt3_err", alloc_err, 0);

        // Fill to capacity, then overflow
        for (int i = 0; i < 7; i++) alloc(2'd2, 5'd1, 1'b1, 5'd2, 1'b1);
        check("fill_tail14", rob_tail, 14);
        check("fill_free1", rob_free, 1);
        alloc(2'd1, 5'd1, 1'b1, 5'd0, 1'b0);
        check("full_tail", rob_tail, 15);
        check("full_count", rob_count, 15);
        check("full_free", rob_free, 0);
        check("full_err0", alloc_err, 0);
        alloc(2'd1, 5'd1, 1'b1, 5'd0, 1'b0);
        check("ovf_err", alloc_err, 1);
        check("ovf_tail", rob_tail, 15);
        check("ovf_count", rob_count, 15);
        idle();
        step();
        check("ovf_err_pulse", alloc_err, 0);

        // In-order retirement after out-of-order completion
        do_reset();
        alloc(2'd2, 5'd3, 1'b1, 5'd7, 1'b0);
        check("ooo_tail", rob_tail, 2);
        wback(1'b0, 4'd0, 1'b1, 4'd1);
        check("ooo_nocommit1", commit_valid_0, 0);
        wback(1'b1, 4'd0, 1'b0, 4'd0);
        check("ooo_nocommit2", commit_valid_0, 0);
        idle();
        step();
        check("ooo_cv0", commit_valid_0, 1);
        check("ooo_cv1", commit_valid_1, 1);
        check("ooo_ce0", commit_entry_0, 0);
        check("ooo_ce1", commit_entry_1, 1);
        check("ooo_rd0", commit_rd_0, 3);
        check("ooo_rd1", commit_rd_1, 7);
        check("ooo_rw0", commit_regwrite_0, 1);
        check("ooo_rw1", commit_regwrite_1, 0);
        check("ooo_head", rob_head, 2);
        check("ooo_count", rob_count, 0);
        step();
        check("ooo_pulse", commit_valid_0, 0);

        // Wrap-around: move head/tail to 14
        do_reset();
        for (int i = 0; i < 7; i++) alloc(2'd2, 5'd1, 1'b1, 5'd2, 1'b1);
        for (int i = 0; i < 7; i++) wback(1'b1, 4'(2 * i), 1'b1, 4'(2 * i + 1));
        idle();
        for (int i = 0; i < 20; i++) begin
            if (rob_count == 5'd0) break;
            step();
        end
        check("wrap_drain", rob_count, 0);
        check("wrap_head14", rob_head, 14);
        check("wrap_tail14", rob_tail, 14);
        alloc(2'd2, 5'd10, 1'b1, 5'd11, 1'b1);
        check("wrap_tail0", rob_tail, 0);
        alloc(2'd2, 5'd12, 1'b0, 5'd13, 1'b1);
        check("wrap_tail2", rob_tail, 2);
        check("wrap_count4", rob_count, 4);
        wback(1'b1, 4'd14, 1'b1, 4'd15);
        wback(1'b1, 4'd0, 1'b1, 4'd1);
        check("wrap_c1_cv1", commit_valid_1, 1);
        check("wrap_c1_ce0", commit_entry_0, 14);
        check("wrap_c1_ce1", commit_entry_1, 15);
        check("wrap_c1_rd0", commit_rd_0, 10);
        check("wrap_c1_rd1", commit_rd_1, 11);
        check("wrap_c1_head", rob_head, 0);
        idle();
        step();
        check("wrap_c2_cv0", commit_valid_0, 1);
        check("wrap_c2_ce0", commit_entry_0, 0);
        check("wrap_c2_ce1", commit_entry_1, 1);
        check("wrap_c2_rd0", commit_rd_0, 12);
        check("wrap_c2_rw0", commit_regwrite_0, 0);
        check("wrap_c2_rd1", commit_rd_1, 13);
        check("wrap_c2_head", rob_head, 2);
        check("wrap_c2_count", rob_count, 0);

        // Full with simultaneous commit: commit does not free same-cycle space
        do_reset();
        fill15();
        wback(1'b1, 4'd0, 1'b0, 4'd0);
        alloc(2'd1, 5'd9, 1'b1, 5'd0, 1'b0);
        check("fc_err", alloc_err, 1);
        check("fc_cv0", commit_valid_0, 1);
        check("fc_cv1", commit_valid_1, 0);
        check("fc_ce0", commit_entry_0, 0);
        check("fc_rd0", commit_rd_0, 0);
        check("fc_count", rob_count, 14);
        check("fc_free", rob_free, 1);
        check("fc_head", rob_head, 1);
        check("fc_tail", rob_tail, 15);

        // Flush with pending commit, same-cycle alloc and writeback
        do_reset();
        alloc(2'd2, 5'd1, 1'b1, 5'd2, 1'b1);
        alloc(2'd2, 5'd3, 1'b1, 5'd4, 1'b1);
        alloc(2'd1, 5'd5, 1'b1, 5'd0, 1'b0);
        check("fl_pre_count", rob_count, 5);
        wback(1'b1, 4'd0, 1'b0, 4'd0);
        idle();
        flush = 1'b1;
        alloc_cnt = 2'd2;
        wb_valid_0 = 1'b1;
        wb_entry_0 = 4'd1;
        step();
        check("fl_count", rob_count, 0);
        check("fl_tail", rob_tail, 0);
        check("fl_head", rob_head, 0);
        check("fl_free", rob_free, 15);
        check("fl_cv0", commit_valid_0, 0);
        check("fl_err", alloc_err, 0);
        wback(1'b1, 4'd1, 1'b1, 4'd0);
        idle();
        step();
        check("fl_oldwb", commit_valid_0, 0);
        check("fl_oldwb_count", rob_count, 0);
        alloc(2'd2, 5'd6, 1'b1, 5'd7, 1'b1);
        idle();
        step();
        step();
        check("fl_done_cleared", commit_valid_0, 0);
        check("fl_new_count", rob_count, 2);

        // Asynchronous reset mid-stream with a commit pending
        do_reset();
        alloc(2'd2, 5'd8, 1'b1, 5'd9, 1'b1);
        wback(1'b1, 4'd0, 1'b1, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_tail", rob_tail, 0);
        check("ar_count", rob_count, 0);
        check("ar_free", rob_free, 15);
        step();
        check("ar_cv0", commit_valid_0, 0);
        check("ar_head", rob_head, 0);
        rst_n = 1'b1;
        step();
        check("ar_after_cv0", commit_valid_0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
